mul_sequencer: RTL and testbench
================================

# mul_sequencer

Multi-cycle controller and iterative datapath for the custom multiply opcode (0001111) flagged by the main decoder's `start_mul`. It accepts one multiply from the execute stage and stalls the pipeline while a radix-2 shift-add engine runs for a fixed number of cycles. It then presents the selected product word and destination register for writeback for exactly one cycle. One instance is shared by the whole core.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; must be a power of two, at least 8.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  `start_mul` qualified by EX-stage valid; sampled only in IDLE.
- `funct3`  in  3  operation select; see Operation.
- `rs1_val`  in  XLEN  multiplicand.
- `rs2_val`  in  XLEN  multiplier.
- `rd_in`  in  5  destination register of the multiply.
- `flush`  in  1  pipeline flush; aborts any operation in progress.
- `stall`  out  1  holds the IF/ID/EX stages.
- `done`  out  1  one-cycle pulse; `result` and `rd_out` are valid.
- `result`  out  XLEN  selected product word.
- `rd_out`  out  5  latched destination register.

## Operation
- funct3 encodings:
  - 000 MUL: low XLEN bits, signedness irrelevant.
  - 001 MULH: high XLEN bits, signed×signed.
  - 010 MULHSU: high XLEN bits, signed rs1 × unsigned rs2.
  - 011 MULHU: high XLEN bits, unsigned×unsigned.
  - 1xx: reserved; runs full latency and returns 0.
- Accept: in IDLE with `start`=1 and `flush`=0, latch funct3, `rd_in` and operand magnitudes. Then go to RUN with the counter at 0.
- Operand magnitudes: if an operand is treated as signed and its MSB is 1, store its two's-complement negation as XLEN unsigned. The most-negative value maps to 2^(XLEN-1) without overflow.
- Negate flag: neg = (signed rs1 & rs1 MSB) XOR (signed rs2 & rs2 MSB).
- RUN, each cycle:
  - If multiplier LSB = 1, add the multiplicand to the upper half of the 2·XLEN accumulator, keeping the carry.
  - Shift the accumulator and the multiplier right by 1.
  - Increment the counter.
- After XLEN RUN cycles, go to DONE.
- DONE:
  - Final product P = neg ? −acc : acc (2·XLEN two's complement).
  - `result` = P[XLEN-1:0] for MUL, else P[2XLEN-1:XLEN]; 0 for reserved funct3.
  - Assert `done` and return to IDLE on the next edge.
- States and transitions:
  - IDLE: to RUN on start & !flush.
  - RUN: to DONE on count == XLEN-1; to IDLE on flush.
  - DONE: to IDLE unconditionally.
- `stall` = (IDLE & `start` & !`flush`) | RUN. It is combinational and low in DONE, so the pipeline advances in the same cycle it consumes `result`.
- `flush` in RUN: return to IDLE next edge, no `done`, counter cleared. `flush` in DONE: `done` still pulses, and the pipeline discards it.
- `start` outside IDLE is ignored; the pipeline is stalled there anyway.

## Timing
- Reset values:
  - state IDLE, counter 0, accumulator 0.
  - `done` 0, `result` 0, `rd_out` 0.
  - `stall` follows the combinational equation with IDLE.
- Latency: accept edge at cycle 0, RUN during cycles 1..XLEN, `done`=1 in cycle XLEN+1. For XLEN=32 that is cycle 33. The latency is fixed and independent of operand values; there is no early-out.
- `result` and `rd_out` are registered and hold their value after `done` until the next DONE.
- Back-to-back: a new `start` is accepted in the cycle after DONE, so the minimum issue interval is XLEN+2 cycles.
- `rst_n` low mid-operation forces IDLE immediately (asynchronous). No `done` follows.

## Structure
- Shared package `mul_pkg`:
  - funct3 constants `MUL_LO`, `MULH_SS`, `MULH_SU`, `MULH_UU`.
  - state enum {IDLE, RUN, DONE}.
  - counter width `$clog2(XLEN)`.
- One sub-module, `mul_shift_add_dp`:
  - Contains the accumulator, multiplier shift register, magnitude conversion and final negate/select.
  - Controlled by `load`, `step` and `finish` strobes.
- The FSM, counter and `stall`/`done` generation stay in `mul_sequencer`.

## Test plan
- MUL 7×6, rd=5: `stall` high cycles 0–32, `done` at cycle 33, `result`=42, `rd_out`=5.
- MUL/MULH 0xFFFFFFFF×0xFFFFFFFF: MUL → 0x00000001; MULH → 0x00000000; MULHU → 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; funct3=101 → 0 at cycle 33.
- Flush at cycle 10 of RUN: no `done`, `stall` low at cycle 11. `start` at cycle 11 is accepted, and its `done` comes 33 cycles later with the correct product.
- `rst_n` low at cycle 20 for 2 cycles: outputs return to reset values immediately, no `done` ever appears, and the next operation completes normally.
- Back-to-back MULs 3×4 then 5×5: `done` at cycles 33 and 67, results 12 and 25, `start` held high throughout.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the multi-cycle multiply unit.
//   - funct3 operation codes
//   - sequencer state encoding
//   - helpers for counter width and operand signedness
package mul_pkg;

  localparam logic [2:0] MUL_LO  = 3'b000;  // low word
  localparam logic [2:0] MULH_SS = 3'b001;  // high word, signed x signed
  localparam logic [2:0] MULH_SU = 3'b010;  // high word, signed x unsigned
  localparam logic [2:0] MULH_UU = 3'b011;  // high word, unsigned x unsigned

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  function automatic int cnt_width(input int xlen);
    return $clog2(xlen);
  endfunction

  // MUL and reserved codes are treated as unsigned: the low word is
  // sign-agnostic and reserved codes return 0 anyway.
  function automatic logic rs1_is_signed(input logic [2:0] f3);
    return (f3 == MULH_SS) || (f3 == MULH_SU);
  endfunction

  function automatic logic rs2_is_signed(input logic [2:0] f3);
    return (f3 == MULH_SS);
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add multiply datapath.
// Works on operand magnitudes, then applies the sign and selects the
// product word.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load                latch funct3, operand magnitudes and sign; clear acc
//   step                one shift-add iteration
//   finish              register selected product word (asserted with the
//                       final step, so the word uses the post-step value)
//   funct3              operation select
//   rs1_val, rs2_val    multiplicand, multiplier
//   result              registered product word, held until next finish
module mul_shift_add_dp
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            finish,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0]   mcand, mplr;
  logic [2*XLEN-1:0] acc;
  logic              neg;
  logic [2:0]        f3_q;

  logic              s1, s2, n1, n2;
  logic [XLEN-1:0]   mag1, mag2, addend;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] acc_nxt, prod;
  logic [XLEN-1:0]   sel;

  assign s1 = rs1_is_signed(funct3);
  assign s2 = rs2_is_signed(funct3);
  assign n1 = s1 & rs1_val[XLEN-1];
  assign n2 = s2 & rs2_val[XLEN-1];
  // Negating the most-negative value yields 2^(XLEN-1), which is its
  // correct magnitude when read as unsigned.
  assign mag1 = n1 ? -rs1_val : rs1_val;
  assign mag2 = n2 ? -rs2_val : rs2_val;

  // Upper half plus multiplicand keeps its carry, which shifts into the MSB.
  assign addend  = mplr[0] ? mcand : '0;
  assign sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
  assign acc_nxt = {sum, acc[XLEN-1:1]};
  assign prod    = neg ? -acc_nxt : acc_nxt;

  always_comb begin
    sel = '0;
    case (f3_q)
      MUL_LO:                    sel = prod[XLEN-1:0];
      MULH_SS, MULH_SU, MULH_UU: sel = prod[2*XLEN-1:XLEN];
      default:                   sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      f3_q   <= '0;
      result <= '0;
    end else begin
      if (load) begin
        mcand <= mag1;
        mplr  <= mag2;
        acc   <= '0;
        neg   <= n1 ^ n2;
        f3_q  <= funct3;
      end else if (step) begin
        acc  <= acc_nxt;
        mplr <= mplr >> 1;
      end
      if (finish) result <= sel;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply controller.
// Accepts one multiply from EX, stalls the pipeline for XLEN shift-add
// cycles, then pulses done for one cycle with the product and rd.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               start_mul qualified by EX valid (sampled in IDLE)
//   funct3              operation select
//   rs1_val, rs2_val    multiplicand, multiplier
//   rd_in               destination register
//   flush               abort any operation in RUN
//   stall               holds IF/ID/EX (combinational)
//   done                one-cycle completion pulse
//   result, rd_out      registered product word and destination register
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int            CW       = cnt_width(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  mul_state_e      state;
  logic [CW-1:0]   cnt;
  logic [4:0]      rd_q;
  logic            accept, step, last;

  assign accept = (state == IDLE) & start & ~flush;
  assign step   = (state == RUN) & ~flush;
  assign last   = step & (cnt == CNT_LAST);

  // stall is low in DONE so the pipeline advances while consuming result.
  assign stall = accept | (state == RUN);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_q   <= '0;
      rd_out <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= RUN;
          cnt   <= '0;
          rd_q  <= rd_in;
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (last) begin
            state  <= DONE;
            cnt    <= '0;
            rd_out <= rd_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mul_shift_add_dp #(.XLEN(XLEN)) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .step    (step),
    .finish  (last),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .result  (result)
  );

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed cases with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_mul_sequencer;

  localparam int XLEN = 32;

  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_val = '0, rs2_val = '0;
  logic [4:0]  rd_in = '0;
  logic        stall, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  mul_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
    .stall(stall), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference product from full-width arithmetic on extended operands.
  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {32'b0, a};
    eb = {32'b0, b};
    if ((f3 == 3'b001 || f3 == 3'b010) && a[31]) ea[63:32] = '1;
    if (f3 == 3'b001 && b[31]) eb[63:32] = '1;
    p = ea * eb;
    case (f3)
      3'b000:                 return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      default:                return 32'h0;
    endcase
  endfunction

  // Model: ph = 0 idle, 1..XLEN busy cycle index, XLEN+1 completion cycle.
  int          ph = 0;
  logic [31:0] m_res = '0, p_res = '0;
  logic [4:0]  m_rd = '0, p_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 0; m_res <= '0; m_rd <= '0;
    end else if (ph == 0) begin
      if (start && !flush) begin
        p_res <= ref_mul(funct3, rs1_val, rs2_val);
        p_rd  <= rd_in;
        ph    <= 1;
      end
    end else if (ph <= XLEN) begin
      if (flush) ph <= 0;
      else if (ph == XLEN) begin
        ph <= XLEN + 1; m_res <= p_res; m_rd <= p_rd;
      end else ph <= ph + 1;
    end else begin
      ph <= 0;
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("m_done",   {31'b0, done}, {31'b0, ph == XLEN + 1});
    chk("m_stall",  {31'b0, stall}, {31'b0, (ph == 0 && start && !flush) || (ph >= 1 && ph <= XLEN)});
    chk("m_result", result, m_res);
    chk("m_rd",     {27'b0, rd_out}, {27'b0, m_rd});
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(output int at, output bit ok);
    ok = 1'b0; at = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; at = cyc; break; end
    end
    chk("done_seen", {31'b0, ok}, 32'd1);
  endtask

  task automatic op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] rd, input logic [31:0] exp);
    int t0, at; bit ok;
    funct3 = f3; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1; t0 = cyc;
    tick(); start = 1'b0;
    wait_done(at, ok);
    chk("latency", 32'(at - t0), 32'd33);
    chk("result",  result, exp);
    chk("rd_out",  {27'b0, rd_out}, {27'b0, rd});
    tick();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t0, at; bit ok, saw;
    #1 rst_n = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", {27'b0, rd_out}, 32'd0);
    tick(); rst_n = 1'b1; tick();

    // Directed products with hand-computed results.
    op(3'b000, 32'd7, 32'd6, 5'd5, 32'd42);
    op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000001);
    op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000);
    op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE);
    op(3'b001, 32'h80000000, 32'h80000000, 5'd4, 32'h40000000);
    op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFF);
    op(3'b101, 32'h12345678, 32'h9ABCDEF0, 5'd7, 32'h00000000);

    // Flush in RUN cycle 10; new op slips in during cycle 11.
    funct3 = 3'b000; rs1_val = 32'd7; rs2_val = 32'd6; rd_in = 5'd5; start = 1'b1;
    tick(); start = 1'b0;
    repeat (9) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    @(negedge clk);
    chk("flush_stall", {31'b0, stall}, 32'd0);
    chk("flush_done",  {31'b0, done}, 32'd0);
    #1;
    funct3 = 3'b000; rs1_val = 32'd9; rs2_val = 32'd11; rd_in = 5'd3; start = 1'b1; t0 = cyc;
    tick(); start = 1'b0;
    wait_done(at, ok);
    chk("flush_lat", 32'(at - t0), 32'd33);
    chk("flush_res", result, 32'd99);
    tick();

    // Async reset at RUN cycle 20 for two cycles.
    funct3 = 3'b011; rs1_val = 32'hFFFFFFFF; rs2_val = 32'hFFFFFFFF; rd_in = 5'd9; start = 1'b1;
    tick(); start = 1'b0;
    repeat (19) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("arst_result", result, 32'd0);
    chk("arst_rd", {27'b0, rd_out}, 32'd0);
    chk("arst_stall", {31'b0, stall}, 32'd0);
    tick(); tick(); rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1'b1;
    end
    chk("arst_no_done", {31'b0, saw}, 32'd0);
    tick();
    op(3'b000, 32'd5, 32'd5, 5'd1, 32'd25);

    // Back-to-back with start held high.
    funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd4; rd_in = 5'd7; start = 1'b1; t0 = cyc;
    tick();
    rs1_val = 32'd5; rs2_val = 32'd5; rd_in = 5'd8;
    wait_done(at, ok);
    chk("b2b_lat1", 32'(at - t0), 32'd33);
    chk("b2b_res1", result, 32'd12);
    wait_done(at, ok);
    chk("b2b_lat2", 32'(at - t0), 32'd67);
    chk("b2b_res2", result, 32'd25);
    chk("b2b_rd2", {27'b0, rd_out}, 32'd8);
    tick(); start = 1'b0; tick();

    // Random traffic: sporadic starts, rare flushes, all funct3 codes.
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom % 4) == 0;
      flush   = ($urandom % 100) == 0;
      funct3  = 3'($urandom);
      rs1_val = pick();
      rs2_val = pick();
      rd_in   = 5'($urandom);
      tick();
    end
    start = 1'b0; flush = 1'b0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
